// File: rtl/multi_clock_divider_pkg.sv
// Shared register map and field positions for the multi-channel clock divider.
package mcd_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  localparam int STAT_PHASE   = 0;
  localparam int STAT_PEND    = 1;
  localparam int STAT_DIV_LSB = 2;
  localparam int STAT_RESYNC  = 0;

  // Channel field width in the word address; a single channel still uses one bit.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Avalon-MM slave bus bundle for the clock divider register file.
interface multi_clock_divider_if #(
  parameter int ADDR_W = 4
);
  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [31:0]       writedata;
  logic              read;
  logic [31:0]       readdata;

  modport master (
    output chipselect, address, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write, writedata, read,
    output readdata
  );
endinterface

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: half-period counter, phase toggle and shadowed divisor
// that only lands on a half-period boundary, idle, disable or resync.
module clkdiv_channel #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 inv,
  input  logic                 div_wr,
  input  logic [CNT_WIDTH-1:0] div_data,
  input  logic                 resync,
  output logic                 clk_out,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] div_active,
  output logic [CNT_WIDTH-1:0] div_shadow,
  output logic                 pend,
  output logic                 phase
);

  logic [CNT_WIDTH-1:0] r_count, r_active, r_shadow;
  logic                 r_phase, r_pend, r_clk_out;

  logic [CNT_WIDTH-1:0] w_count_nxt, w_active_nxt, w_shadow_nxt;
  logic                 w_phase_nxt, w_pend_nxt;
  logic                 w_idle, w_tc, w_load;

  assign w_idle = resync || !en || (r_active == '0);
  assign w_tc   = (r_active != '0) && (r_count == r_active - CNT_WIDTH'(1));
  assign w_load = r_pend && (w_idle || w_tc);

  always_comb begin
    w_count_nxt  = r_count + CNT_WIDTH'(1);
    w_phase_nxt  = r_phase;
    w_active_nxt = w_load ? r_shadow : r_active;
    w_shadow_nxt = div_wr ? div_data : r_shadow;
    w_pend_nxt   = div_wr ? 1'b1 : (w_load ? 1'b0 : r_pend);
    if (w_idle) begin
      w_count_nxt = '0;
      w_phase_nxt = 1'b0;
    end else if (w_tc) begin
      w_count_nxt = '0;
      w_phase_nxt = ~r_phase;
    end
  end

  // Output is taken from the next phase so clk_out is a plain flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_phase   <= 1'b0;
      r_pend    <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_active  <= w_active_nxt;
      r_shadow  <= w_shadow_nxt;
      r_phase   <= w_phase_nxt;
      r_pend    <= w_pend_nxt;
      r_clk_out <= w_phase_nxt ^ inv;
    end
  end

  assign clk_out    = r_clk_out;
  assign count      = r_count;
  assign div_active = r_active;
  assign div_shadow = r_shadow;
  assign pend       = r_pend;
  assign phase      = r_phase;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider behind an Avalon-MM slave:
// address decode, per-channel CTRL, registered read mux and channel array.
module multi_clock_divider
  import mcd_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_clock_divider_if.slave bus,
  output logic [CHANNELS-1:0]  clk_out
);

  localparam int                CH_BITS = ch_bits(CHANNELS);
  localparam logic [CH_BITS:0]  LP_NCH  = (CH_BITS + 1)'(CHANNELS);

  logic [CH_BITS-1:0] w_ch;
  logic [1:0]         w_reg;
  logic               w_ch_ok, w_wr, w_rd, w_resync;

  assign w_ch     = bus.address[CH_BITS+1:2];
  assign w_reg    = bus.address[1:0];
  assign w_ch_ok  = ({1'b0, w_ch} < LP_NCH);
  assign w_wr     = bus.chipselect && bus.write && w_ch_ok;
  assign w_rd     = bus.chipselect && bus.read;
  assign w_resync = w_wr && (w_reg == REG_STATUS) && bus.writedata[STAT_RESYNC];

  logic [CHANNELS-1:0] r_en, r_inv;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en  <= '0;
      r_inv <= '0;
    end else if (w_wr && (w_reg == REG_CTRL)) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_ch == CH_BITS'(i)) begin
          r_en[i]  <= bus.writedata[CTRL_EN];
          r_inv[i] <= bus.writedata[CTRL_INV];
        end
      end
    end
  end

  logic [CNT_WIDTH-1:0] w_count  [CHANNELS];
  logic [CNT_WIDTH-1:0] w_div_act[CHANNELS];
  logic [CNT_WIDTH-1:0] w_div_sh [CHANNELS];
  logic [CHANNELS-1:0]  w_pend, w_phase, w_div_wr;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_div_wr[g] = w_wr && (w_reg == REG_DIV) && (w_ch == CH_BITS'(g));

    clkdiv_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en         (r_en[g]),
      .inv        (r_inv[g]),
      .div_wr     (w_div_wr[g]),
      .div_data   (bus.writedata[CNT_WIDTH-1:0]),
      .resync     (w_resync),
      .clk_out    (clk_out[g]),
      .count      (w_count[g]),
      .div_active (w_div_act[g]),
      .div_shadow (w_div_sh[g]),
      .pend       (w_pend[g]),
      .phase      (w_phase[g])
    );
  end

  // Channels outside CHANNELS never match the loop, so they read as zero.
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_ch == CH_BITS'(i)) begin
        case (w_reg)
          REG_CTRL: begin
            w_rdata[CTRL_EN]  = r_en[i];
            w_rdata[CTRL_INV] = r_inv[i];
          end
          REG_DIV:   w_rdata = 32'(w_div_sh[i]);
          REG_COUNT: w_rdata = 32'(w_count[i]);
          default:   w_rdata = 32'({w_div_act[i], w_pend[i], w_phase[i]});
        endcase
      end
    end
  end

  logic [31:0] r_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: register table, read scoreboard and
// cycle-accurate waveform sequences on a 4-channel and a 3-channel instance.
module tb_multi_clock_divider;
  import mcd_pkg::*;

  localparam int T = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #(T/2) clk = ~clk;

  multi_clock_divider_if #(.ADDR_W(4)) bus  ();
  multi_clock_divider_if #(.ADDR_W(4)) bus2 ();
  logic [3:0] clk_out;
  logic [2:0] clk_out2;

  multi_clock_divider #(.CHANNELS(4), .CNT_WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .clk_out (clk_out)
  );

  multi_clock_divider #(.CHANNELS(3), .CNT_WIDTH(8)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus2),
    .clk_out (clk_out2)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] A(input int ch, input logic [1:0] r);
    return {ch[1:0], r};
  endfunction

  // Bus tasks: called at posedge+1, access is sampled at the next edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
    bus.address = a; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = a;
    sbq.push_back('{exp, 32'hFFFF_FFFF, name});
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic wr2(input logic [3:0] a, input logic [31:0] d);
    bus2.chipselect = 1'b1; bus2.write = 1'b1; bus2.read = 1'b0;
    bus2.address = a; bus2.writedata = d;
    @(posedge clk); #1;
    bus2.chipselect = 1'b0; bus2.write = 1'b0;
  endtask

  task automatic rd2(input logic [3:0] a, output logic [31:0] v);
    bus2.chipselect = 1'b1; bus2.read = 1'b1; bus2.write = 1'b0; bus2.address = a;
    @(posedge clk); #1;
    v = bus2.readdata;
    bus2.chipselect = 1'b0; bus2.read = 1'b0;
  endtask

  // Cycles until the selected output changes, sampled 1 time unit after each edge.
  task automatic wait_toggle(input bit second, input int idx, output int n);
    logic prev, cur;
    prev = second ? clk_out2[idx] : clk_out[idx];
    cur  = prev;
    n = 0;
    while (cur == prev && n < 600) begin
      @(posedge clk); #1;
      n++;
      cur = second ? clk_out2[idx] : clk_out[idx];
    end
    if (cur == prev) begin
      checks++;
      errors++;
      $display("FAIL toggle timeout: ch%0d no edge in %0d cycles", idx, n);
    end
  endtask

  // Scoreboard: readdata is compared one cycle after each accepted read.
  logic rd_seen = 1'b0;
  always @(posedge clk) rd_seen <= bus.chipselect && bus.read;

  always @(negedge clk) begin
    if (rd_seen) begin
      sb_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected read data %h", bus.readdata);
      end else begin
        e = sbq.pop_front();
        if ((bus.readdata & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, bus.readdata, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] v;
    logic [5:0] pat1;
    logic [3:0] pat0, pat2, pat3;

    bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.address = '0; bus.writedata = '0;
    bus2.chipselect = 0; bus2.write = 0; bus2.read = 0; bus2.address = '0; bus2.writedata = '0;

    vecs[0]  = '{1'b0, A(0, REG_CTRL),   32'h0,         32'h0,         "rst ctrl0"};
    vecs[1]  = '{1'b0, A(0, REG_DIV),    32'h0,         32'h0,         "rst div0"};
    vecs[2]  = '{1'b0, A(0, REG_STATUS), 32'h0,         32'h0,         "rst status0"};
    vecs[3]  = '{1'b0, A(2, REG_COUNT),  32'h0,         32'h0,         "rst count2"};
    vecs[4]  = '{1'b1, A(1, REG_CTRL),   32'hFFFF_FFFC, 32'h0,         "wr ctrl1 junk"};
    vecs[5]  = '{1'b0, A(1, REG_CTRL),   32'h0,         32'h0,         "ctrl1 upper bits"};
    vecs[6]  = '{1'b1, A(1, REG_CTRL),   32'h2,         32'h0,         "wr ctrl1 inv"};
    vecs[7]  = '{1'b0, A(1, REG_CTRL),   32'h0,         32'h2,         "ctrl1 inv"};
    vecs[8]  = '{1'b1, A(2, REG_DIV),    32'hDEAD_BEEF, 32'h0,         "wr div2"};
    vecs[9]  = '{1'b0, A(2, REG_DIV),    32'h0,         32'hDEAD_BEEF, "div2 shadow"};
    vecs[10] = '{1'b0, A(2, REG_STATUS), 32'h0,         32'h7AB6_FBBC, "status2 loaded trunc"};
    vecs[11] = '{1'b1, A(2, REG_DIV),    32'h0,         32'h0,         "wr div2 zero"};
    vecs[12] = '{1'b0, A(2, REG_DIV),    32'h0,         32'h0,         "div2 zero"};
    vecs[13] = '{1'b0, A(2, REG_STATUS), 32'h0,         32'h0,         "status2 zero"};
    vecs[14] = '{1'b1, A(1, REG_CTRL),   32'h0,         32'h0,         "wr ctrl1 off"};
    vecs[15] = '{1'b0, A(1, REG_CTRL),   32'h0,         32'h0,         "ctrl1 off"};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset clk_out", 32'(clk_out), 32'h0);
    chk("reset readdata", bus.readdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else               rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // ch0 DIV=2: period 4, first rise two cycles after enable takes effect
    wr(A(0, REG_DIV), 32'd2);
    wr(A(0, REG_CTRL), 32'd1);
    pat1 = 6'b100110;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t1 wave c%0d", k), 32'(clk_out[0]), 32'(pat1[k]));
    end
    rd(A(0, REG_STATUS), 32'h9, "t1 status");

    // ch1 DIV=3 running, retarget to 5 mid half-period
    wr(A(1, REG_DIV), 32'd3);
    wr(A(1, REG_CTRL), 32'd1);
    wait_toggle(1'b0, 1, n);
    chk("t2 first half", 32'(n), 32'd3);
    wr(A(1, REG_DIV), 32'd5);
    rd(A(1, REG_STATUS), 32'hF, "t2 pend set");
    wait_toggle(1'b0, 1, n);
    chk("t2 old half kept", 32'(n + 2), 32'd3);
    wait_toggle(1'b0, 1, n);
    chk("t2 new half a", 32'(n), 32'd5);
    wait_toggle(1'b0, 1, n);
    chk("t2 new half b", 32'(n), 32'd5);
    rd(A(1, REG_STATUS), 32'h14, "t2 pend cleared");

    // Global resync with ch0 DIV=2 and ch2 DIV=4
    wr(A(2, REG_DIV), 32'd4);
    wr(A(2, REG_CTRL), 32'd1);
    wr(A(0, REG_STATUS), 32'd1);
    chk("t3 all low after resync", 32'(clk_out), 32'h0);
    rd(A(2, REG_COUNT), 32'h0, "t3 ch2 count zero");
    chk("t3 ch0 c1", 32'(clk_out[0]), 32'h0);
    chk("t3 ch2 c1", 32'(clk_out[2]), 32'h0);
    pat0 = 4'b0011;
    pat2 = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t3 ch0 c%0d", k + 2), 32'(clk_out[0]), 32'(pat0[k]));
      chk($sformatf("t3 ch2 c%0d", k + 2), 32'(clk_out[2]), 32'(pat2[k]));
    end

    // ch3 EN+INV with DIV=1, then disable with INV kept
    wr(A(3, REG_CTRL), 32'd3);
    wr(A(3, REG_DIV), 32'd1);
    chk("t4 start high", 32'(clk_out[3]), 32'h1);
    pat3 = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t4 wave c%0d", k), 32'(clk_out[3]), 32'(pat3[k]));
    end
    wr(A(3, REG_CTRL), 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t4 held c%0d", k), 32'(clk_out[3]), 32'h1);
    end
    rd(A(3, REG_COUNT), 32'h0, "t4 count idle");
    rd(A(3, REG_CTRL), 32'h2, "t4 ctrl");

    // 3-channel, 8-bit instance: out-of-range channel, read hold, wrap divisor
    wr2(A(0, REG_DIV), 32'hFF);
    rd2(A(0, REG_DIV), v);
    chk("t5 div0 readback", v, 32'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5 readdata hold", bus2.readdata, 32'hFF);
    wr2(A(3, REG_DIV), 32'h55);
    wr2(A(3, REG_CTRL), 32'h3);
    rd2(A(3, REG_DIV), v);
    chk("t5 oor div", v, 32'h0);
    rd2(A(3, REG_CTRL), v);
    chk("t5 oor ctrl", v, 32'h0);
    rd2(A(3, REG_STATUS), v);
    chk("t5 oor status", v, 32'h0);
    rd2(A(0, REG_DIV), v);
    chk("t5 div0 untouched", v, 32'hFF);
    chk("t5 outputs idle", 32'(clk_out2), 32'h0);
    wr2(A(0, REG_CTRL), 32'h1);
    wait_toggle(1'b1, 0, n);
    chk("t5 wrap half a", 32'(n), 32'd255);
    wait_toggle(1'b1, 0, n);
    chk("t5 wrap half b", 32'(n), 32'd255);
    rd2(A(0, REG_STATUS), v);
    chk("t5 status 8b", v, 32'h3FC);
    rd2(A(0, REG_COUNT), v);
    chk("t5 count", v, 32'h1);

    // Reset pulse while every channel runs with DIV=7
    for (int c = 0; c < 4; c++) begin
      wr(A(c, REG_DIV), 32'd7);
      wr(A(c, REG_CTRL), 32'd1);
    end
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6 clk_out zero", 32'(clk_out), 32'h0);
    chk("t6 clk_out2 zero", 32'(clk_out2), 32'h0);
    chk("t6 readdata zero", bus.readdata, 32'h0);
    chk("t6 readdata2 zero", bus2.readdata, 32'h0);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd(A(c, 2'(r)), 32'h0, $sformatf("t6 ch%0d reg%0d", c, r));
      end
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scoreboard drained", 32'(sbq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
Parametrised multi-channel programmable clock divider. It is an Avalon-MM slave that succeeds the single-channel My_ClockDivider. It provides CHANNELS independent divided outputs, each with enable, polarity control, glitch-free divisor update, readback and a global phase-resync command. It sits on the HPS/Nios lightweight bus and drives low-speed peripheral clocks and strobes in the fabric.

Parameters:
CHANNELS, 4, number of divider channels (1..16)
CNT_WIDTH, 32, width of divisor and counter registers (8..32)
CH_BITS, derived $clog2(CHANNELS) (min 1), channel field width in address

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
address  in  CH_BITS+2  word address: [CH_BITS+1:2]=channel, [1:0]=register
write  in  1  write strobe, qualified by chipselect
writedata  in  32  write data
read  in  1  read strobe, qualified by chipselect
readdata  out  32  registered read data
clk_out  out  CHANNELS  divided outputs, bit i = channel i

Behaviour:
- Reset (synchronous, active-high): all CTRL, DIV_SHADOW, DIV_ACTIVE, counter, phase and pending flags = 0; clk_out = 0; readdata = 0.
- Register map per channel:
  - 0 CTRL (RW): bit0 EN, bit1 INV; other bits read 0.
  - 1 DIV (RW): writes DIV_SHADOW[CNT_WIDTH-1:0] and sets PEND. Reads return DIV_SHADOW.
  - 2 COUNT (RO): current counter value.
  - 3 STATUS: read returns bit0 = raw phase, bit1 = PEND, bits[CNT_WIDTH+1:2] = DIV_ACTIVE (truncated to 32). A write with bit0 = 1 issues a global RESYNC.
- Write accepted when chipselect & write; it takes effect at that clock edge.
- Read: readdata is valid 1 cycle after chipselect & read. readdata holds its value otherwise.
- Out-of-range channel (index ≥ CHANNELS): writes ignored, reads return 0.
- Channel operation, half-period = DIV_ACTIVE clk cycles:
  - EN=1, DIV_ACTIVE≠0: counter increments each cycle. When counter == DIV_ACTIVE-1: counter←0, phase toggles, and if PEND then DIV_ACTIVE←DIV_SHADOW, PEND←0.
  - Output period is 2·DIV_ACTIVE cycles at 50% duty.
  - clk_out[i] = phase XOR INV. It is registered, so there is no combinational glitch.
  - DIV_ACTIVE = 0 with EN=1: the shadow is loaded on the next cycle if PEND, otherwise the channel idles (counter 0, phase 0).
  - EN=0: counter←0, phase←0, output = INV. PEND/DIV_SHADOW are retained, and a pending shadow loads into DIV_ACTIVE immediately.
  - Divisor change mid-period: the current half-period completes with the old value. The new value applies from the next half-period, so there is no runt pulse.
  - Wrap: DIV = 2^CNT_WIDTH-1 is legal, and the counter never exceeds DIV_ACTIVE-1.
- RESYNC, next edge: every channel has counter←0 and phase←0. Pending shadows are loaded and PEND cleared. All enabled channels restart aligned.
  - RESYNC takes priority over a terminal-count toggle in the same cycle.
- Disabling mid-period forces the output to INV on the next edge. Re-enabling starts a fresh half-period from counter 0.
- Reset mid-operation overrides everything on that edge.

Decomposition:
- Package mcd_pkg holds:
  - register offsets REG_CTRL=0, REG_DIV=1, REG_COUNT=2, REG_STATUS=3;
  - CTRL bit indices CTRL_EN=0, CTRL_INV=1;
  - STATUS bit indices.
- Sub-module clkdiv_channel (params CNT_WIDTH):
  - inputs clk, reset, en, inv, div_wr, div_data, resync;
  - outputs clk_out, count, div_active, pend, phase.
- Top: Avalon decode, readdata mux/register, and a generate loop over CHANNELS.

Test Plan:
1. Reset, then write ch0 DIV=2, then CTRL=1 → clk_out[0] toggles every 2 cycles (period 4, high 2/low 2). STATUS read shows PEND=0, DIV_ACTIVE=2.
2. ch1 DIV=3 EN=1 running, write DIV=5 mid half-period → current half-period stays 3 cycles, subsequent half-periods 5. PEND reads 1 until the load.
3. ch0 DIV=2, ch2 DIV=4, both enabled, write STATUS bit0=1 → the edge after the write has both counters 0 and both outputs low. ch0 rises 2 cycles later, ch2 rises 4 cycles later.
4. ch3 CTRL=3 (EN+INV), DIV=1 → output toggles every cycle, starting high. Then CTRL=2 → output held 1, COUNT reads 0.
5. Access channel index CHANNELS (when CH_BITS permits) → write ignored, read returns 32'h0. Read latency is exactly 1 cycle on every register.
6. Assert reset for 1 cycle while all channels run with DIV=7 → next edge all clk_out=0, every register reads 0.
